beat_sequencer: RTL and testbench
=================================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Parameter W, default 12, width of the beat index.
REQ-002 Parameter LEN, default 4095, number of beats; ibeat ranges 0..LEN-1; legal 2 <= LEN <= 2^W.
REQ-003 Parameter SLOW_DIV, default 2, tick divisor applied in slow mode; legal SLOW_DIV >= 2.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  beat-rate enable, one clk wide per beat period.
REQ-007 play  in  1  level; 1 = run, 0 = pause.
REQ-008 slow  in  1  level; 1 = advance once per SLOW_DIV ticks.
REQ-009 mode  in  1  level; 1 = loop, 0 = one-shot.
REQ-010 rewind  in  1  synchronous; return to beat 0 and IDLE.
REQ-011 ibeat  out  W  current beat index, registered.
REQ-012 playing  out  1  high while state is RUN.
REQ-013 done  out  1  high while state is END.
REQ-014 wrap  out  1  one-clk pulse when ibeat wraps LEN-1 -> 0 in loop mode.

Function
REQ-015 FSM states: IDLE, RUN, HOLD, END; all outputs registered (Moore style; wrap registered with the wrap edge).
REQ-016 Transitions: IDLE->RUN when play=1; RUN->HOLD when play=0; HOLD->RUN when play=1; RUN->END on one-shot terminal advance; END holds until rewind.
REQ-017 rewind=1 has top priority in every state: next state IDLE, ibeat=0, slow prescaler=0, wrap=0.
REQ-018 Advance qualifier: state is RUN (pre-edge) AND tick=1 AND (slow=0 OR prescaler == SLOW_DIV-1).
REQ-019 Prescaler counts qualified ticks (RUN, tick=1, slow=1) modulo SLOW_DIV; cleared while slow=0; held in HOLD, IDLE, END.
REQ-020 On advance with ibeat < LEN-1: ibeat <= ibeat+1, computed in W+1 bits.
REQ-021 On advance with ibeat == LEN-1 and mode=1: ibeat <= 0, wrap=1 for exactly one clk; state stays RUN.
REQ-022 On advance with ibeat == LEN-1 and mode=0: ibeat stays LEN-1, state <= END.
REQ-023 No advance occurs in the cycle of an IDLE->RUN or HOLD->RUN transition, even if tick=1.
REQ-024 If play falls in the same cycle as a qualified tick, that advance still occurs (RUN is the pre-edge state); state then goes HOLD.
REQ-025 ibeat is held in IDLE, HOLD and END.
REQ-026 mode and slow are sampled every cycle; a change takes effect on the next advance decision; mode change while in END does not leave END.
REQ-027 ibeat never exceeds LEN-1.

Reset
REQ-028 reset=1 asynchronously forces state IDLE, ibeat=0, prescaler=0, playing=0, done=0, wrap=0.
REQ-029 Reset asserted mid-operation (any state) takes effect immediately, with no partial update on the following edge.
REQ-030 After reset release, no advance until play=1 has moved the FSM to RUN.

Verification (W=4, LEN=8, SLOW_DIV=2 unless stated)
REQ-031 Loop: play=1, mode=1, tick every clk -> ibeat 0..7,0,1; wrap high exactly one clk coincident with ibeat=0 after 7; playing=1 throughout.
REQ-032 One-shot: mode=0, tick every clk -> ibeat stops at 7; done=1, playing=0; further ticks leave ibeat=7; rewind -> ibeat=0, IDLE, done=0.
REQ-033 Slow: slow=1, tick every clk -> ibeat increments every 2nd tick; toggling slow to 0 mid-count clears prescaler; next tick advances.
REQ-034 Pause: play drops at ibeat=3 on a tick cycle -> ibeat=4 then held through 10 ticks; play=1 -> resumes 5 one cycle after the transition.
REQ-035 Async reset at ibeat=5 mid-clk -> ibeat=0, all flags 0 before next edge; rewind and play both 1 -> IDLE wins.
REQ-036 Defaults: W=12, LEN=4095 loop -> ibeat wraps 4094 -> 0, never reaches 4095.

Source files
------------

// File: rtl/beat_sequencer.sv
// Beat sequencer: steps a beat index at the tick rate (optionally divided),
// with play/pause, loop or one-shot end behaviour and a synchronous rewind.
module beat_sequencer #(
  parameter int unsigned W        = 12,
  parameter int unsigned LEN      = 4095,
  parameter int unsigned SLOW_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         play,
  input  logic         slow,
  input  logic         mode,
  input  logic         rewind,
  output logic [W-1:0] ibeat,
  output logic         playing,
  output logic         done,
  output logic         wrap
);

  localparam int unsigned PW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [W-1:0]  LAST_BEAT = W'(LEN - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(SLOW_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_END  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ibeat_q, ibeat_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          wrap_q, wrap_d;
  logic          playing_q, playing_d;
  logic          done_q, done_d;
  logic          advance_c;
  logic [W:0]    beat_inc_c;

  // State and output registers; reset is asynchronous so flags clear at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ibeat_q   <= '0;
      pre_q     <= '0;
      wrap_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ibeat_q   <= ibeat_d;
      pre_q     <= pre_d;
      wrap_q    <= wrap_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  // Next-state, prescaler and beat-index logic; rewind overrides everything.
  always_comb begin
    state_d    = state_q;
    ibeat_d    = ibeat_q;
    pre_d      = pre_q;
    wrap_d     = 1'b0;
    advance_c  = 1'b0;
    beat_inc_c = {1'b0, ibeat_q} + (W+1)'(1);

    if (rewind) begin
      state_d = ST_IDLE;
      ibeat_d = '0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (play) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Prescaler only counts ticks while slow; leaving slow clears it.
          if (!slow) begin
            pre_d = '0;
          end else if (tick) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
          end
          advance_c = tick && (!slow || (pre_q == PRE_LAST));

          if (!play) state_d = ST_HOLD;

          if (advance_c) begin
            if (ibeat_q != LAST_BEAT) begin
              ibeat_d = beat_inc_c[W-1:0];
            end else if (mode) begin
              ibeat_d = '0;
              wrap_d  = 1'b1;
            end else begin
              // Terminal one-shot advance ends the run even if pausing.
              state_d = ST_END;
            end
          end
        end
        ST_HOLD: begin
          if (play) state_d = ST_RUN;
        end
        ST_END: begin
          state_d = ST_END;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    playing_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_END);
  end

  assign ibeat   = ibeat_q;
  assign playing = playing_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Randomized self-checking bench for beat_sequencer against a behavioural model.
module tb_beat_sequencer;

  localparam int unsigned W   = 4;
  localparam int unsigned LEN = 8;
  localparam int unsigned SD  = 2;

  logic         clk = 1'b0;
  logic         reset, tick, play, slow, mode, rewind;
  logic [W-1:0] ibeat;
  logic         playing, done, wrap;

  logic         d_reset, d_tick, d_play, d_slow, d_mode, d_rewind;
  logic [11:0]  d_ibeat;
  logic         d_playing, d_done, d_wrap;

  int total = 0;
  int bad   = 0;

  // Model state: beat position, tick count toward the slow divisor, phase name.
  int    m_beat, m_cnt, m_wrap;
  string m_phase;

  always #5 clk = ~clk;

  beat_sequencer #(.W(W), .LEN(LEN), .SLOW_DIV(SD)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .play(play), .slow(slow),
    .mode(mode), .rewind(rewind), .ibeat(ibeat), .playing(playing),
    .done(done), .wrap(wrap)
  );

  beat_sequencer u_def (
    .clk(clk), .reset(d_reset), .tick(d_tick), .play(d_play), .slow(d_slow),
    .mode(d_mode), .rewind(d_rewind), .ibeat(d_ibeat), .playing(d_playing),
    .done(d_done), .wrap(d_wrap)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beat  = 0;
    m_cnt   = 0;
    m_wrap  = 0;
    m_phase = "idle";
  endtask

  // One clock of the reference behaviour, using the inputs held at the edge.
  task automatic model_edge();
    bit moves;
    m_wrap = 0;
    if (rewind) begin
      model_reset();
      return;
    end
    if (m_phase == "idle" || m_phase == "hold") begin
      if (play) m_phase = "run";
      return;
    end
    if (m_phase != "run") return;
    moves = 0;
    if (!slow) begin
      m_cnt = 0;
      moves = tick;
    end else if (tick) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == SD) begin
        m_cnt = 0;
        moves = 1;
      end
    end
    if (!play) m_phase = "hold";
    if (moves) begin
      if (m_beat + 1 < LEN) m_beat = m_beat + 1;
      else if (mode) begin
        m_beat = 0;
        m_wrap = 1;
      end else m_phase = "end";
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".ibeat"}, int'(ibeat), m_beat);
    check_val({tag, ".playing"}, int'(playing), int'(m_phase == "run"));
    check_val({tag, ".done"}, int'(done), int'(m_phase == "end"));
    check_val({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  task automatic step(input bit t, input bit p, input bit s, input bit md,
                      input bit rw, input string tag);
    @(negedge clk);
    tick = t; play = p; slow = s; mode = md; rewind = rw;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges must clear everything before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick = 0; play = 0; rewind = 0;
  endtask

  initial begin
    int max_seen, wraps, prev;
    reset = 1'b1; tick = 0; play = 0; slow = 0; mode = 0; rewind = 0;
    d_reset = 1'b1; d_tick = 0; d_play = 0; d_slow = 0; d_mode = 1; d_rewind = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 1'b0;
    d_reset = 1'b0;

    // Ticks with play low must not move the beat.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, "idle_tick");

    // Loop: tick every clock across one full wrap.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 1, 0, "loop");
    step(0, 1, 0, 1, 1, "loop_rewind");

    // One-shot to the end, extra ticks, mode flip in end, then rewind.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, "oneshot");
    step(1, 1, 0, 1, 0, "end_mode");
    check_val("end_beat", int'(ibeat), LEN - 1);
    step(0, 1, 0, 0, 1, "end_rewind");

    // Slow mode, then drop slow mid-count.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, "slow");
    step(0, 1, 1, 1, 0, "slow_gap");
    step(1, 1, 0, 1, 0, "slow_clear");
    step(1, 1, 0, 1, 0, "fast");
    step(0, 1, 0, 1, 1, "slow_rewind");

    // Pause: play falls on a tick at beat 3, ticks while held, then resume.
    step(1, 1, 0, 1, 0, "pause_start");
    while (m_beat != 3) step(1, 1, 0, 1, 0, "pause_run");
    step(1, 0, 0, 1, 0, "pause_drop");
    check_val("pause_beat", int'(ibeat), 4);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0, "pause_hold");
    step(1, 1, 0, 1, 0, "pause_resume");
    step(1, 1, 0, 1, 0, "pause_next");
    check_val("resume_beat", int'(ibeat), 5);

    // Async reset mid-cycle, then rewind together with play.
    async_reset("async_rst");
    step(1, 1, 0, 1, 1, "rewind_play");

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      else step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 9) < 8),
                bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) != 0),
                bit'($urandom_range(0, 39) == 0), "rnd");
    end

    // Default parameters in loop mode: wraps from 4094, never shows 4095.
    max_seen = 0; wraps = 0; prev = 0;
    @(negedge clk);
    d_play = 1; d_tick = 1; d_mode = 1;
    for (int i = 0; i < 4200; i++) begin
      @(posedge clk);
      #1;
      if (int'(d_ibeat) > max_seen) max_seen = int'(d_ibeat);
      if (d_wrap) begin
        wraps++;
        check_val("def_wrap_from", prev, 4094);
        check_val("def_wrap_to", int'(d_ibeat), 0);
      end
      prev = int'(d_ibeat);
    end
    check_val("def_max", max_seen, 4094);
    check_val("def_wraps", wraps, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
